// File: rtl/spi_slave_rx.sv
// ---------------------------------------------------------------------------
// spi_slave_rx
//   SPI mode-0 slave (CPOL=0, CPHA=0, MSB first, SS active-low). The serial
//   pins are oversampled in the clk domain. Each received word is presented
//   on a parallel bus with a one-cycle valid pulse. A one-word TX buffer
//   supplies the reply word that is shifted out on MISO in the next frame.
//
// Ports
//   clk       system clock (SCLK half-period must be >= 4 clk periods)
//   rst       synchronous active-high reset
//   SCLK      serial clock from the master (asynchronous)
//   SS        slave select from the master, active-low (asynchronous)
//   MOSI      serial data from the master (asynchronous)
//   MISO      serial data to the master
//   tx_data   reply word for the next frame
//   tx_valid  tx_data offered; accepted when tx_valid & tx_ready
//   tx_ready  TX buffer empty
//   rx_data   last complete received word
//   rx_valid  1-clk pulse: rx_data just updated
//   busy      frame in progress
//   abort     1-clk pulse: SS released before width bits were received
// ---------------------------------------------------------------------------
module spi_slave_rx #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SCLK,
    input  logic             SS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [width-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [width-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             abort
);

    localparam int CW = $clog2(width + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(width - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_WAIT_END = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic sclk_s1_r, sclk_s2_r, sclk_h_r;
    logic ss_s1_r, ss_s2_r, ss_h_r;
    logic mosi_s1_r, mosi_s2_r;

    logic [width-1:0] tx_buf_r;
    logic             tx_ready_r;
    logic [width-1:0] tx_shift_r;
    logic [width-1:0] rx_shift_r;
    logic [width-1:0] rx_data_r;
    logic [CW-1:0]    count_r;
    logic             miso_r;
    logic             rx_valid_r;
    logic             busy_r;
    logic             abort_r;

    logic sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s;
    logic start_s, shift_in_s, shift_out_s, done_s, abort_s;
    logic accept_s;
    logic [width-1:0] tx_load_s;
    logic [width-1:0] rx_next_s;

    // Edges are the difference between the synchronized value and its history.
    assign sclk_rise_s = sclk_s2_r & ~sclk_h_r;
    assign sclk_fall_s = ~sclk_s2_r & sclk_h_r;
    assign ss_rise_s   = ss_s2_r & ~ss_h_r;
    assign ss_fall_s   = ~ss_s2_r & ss_h_r;

    assign accept_s  = tx_valid & tx_ready_r;
    // An empty buffer sends an all-zero reply.
    assign tx_load_s = tx_ready_r ? {width{1'b0}} : tx_buf_r;
    assign rx_next_s = {rx_shift_r[width-2:0], mosi_s2_r};

    assign MISO     = miso_r;
    assign tx_ready = tx_ready_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign busy     = busy_r;
    assign abort    = abort_r;

    // Two-flop synchronizers plus history flops for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_r <= 1'b0;
            sclk_s2_r <= 1'b0;
            sclk_h_r  <= 1'b0;
            ss_s1_r   <= 1'b0;
            ss_s2_r   <= 1'b0;
            ss_h_r    <= 1'b0;
            mosi_s1_r <= 1'b0;
            mosi_s2_r <= 1'b0;
        end else begin
            sclk_s1_r <= SCLK;
            sclk_s2_r <= sclk_s1_r;
            sclk_h_r  <= sclk_s2_r;
            ss_s1_r   <= SS;
            ss_s2_r   <= ss_s1_r;
            ss_h_r    <= ss_s2_r;
            mosi_s1_r <= MOSI;
            mosi_s2_r <= mosi_s1_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and action strobes; an SS edge takes priority over SCLK.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        shift_in_s   = 1'b0;
        shift_out_s  = 1'b0;
        done_s       = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    state_next_s = ST_SHIFT;
                    start_s      = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Leaving SHIFT at the last bit means any SS rise here is early.
                if (ss_rise_s) begin
                    state_next_s = ST_IDLE;
                    abort_s      = 1'b1;
                end else if (sclk_rise_s) begin
                    shift_in_s = 1'b1;
                    if (count_r == LAST_BIT) begin
                        done_s       = 1'b1;
                        state_next_s = ST_WAIT_END;
                    end else begin
                        state_next_s = ST_SHIFT;
                    end
                end else if (sclk_fall_s) begin
                    shift_out_s  = 1'b1;
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            ST_WAIT_END: begin
                if (ss_rise_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_END;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // TX buffer: a same-cycle handshake at frame start fills it for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_buf_r   <= {width{1'b0}};
            tx_ready_r <= 1'b1;
        end else if (accept_s) begin
            tx_buf_r   <= tx_data;
            tx_ready_r <= 1'b0;
        end else if (start_s) begin
            tx_ready_r <= 1'b1;
        end
    end

    // Datapath: shift registers, bit counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift_r <= {width{1'b0}};
            rx_shift_r <= {width{1'b0}};
            rx_data_r  <= {width{1'b0}};
            count_r    <= {CW{1'b0}};
            miso_r     <= 1'b0;
            rx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            abort_r    <= 1'b0;
        end else begin
            rx_valid_r <= done_s;
            abort_r    <= abort_s;
            busy_r     <= (state_next_s != ST_IDLE);
            if (start_s) begin
                tx_shift_r <= tx_load_s;
                rx_shift_r <= {width{1'b0}};
                count_r    <= {CW{1'b0}};
                miso_r     <= tx_load_s[width-1];
            end else if (shift_in_s) begin
                rx_shift_r <= rx_next_s;
                count_r    <= count_r + {{(CW-1){1'b0}}, 1'b1};
                if (done_s) begin
                    rx_data_r <= rx_next_s;
                    miso_r    <= 1'b0;
                end
            end else if (shift_out_s) begin
                tx_shift_r <= {tx_shift_r[width-2:0], 1'b0};
                miso_r     <= tx_shift_r[width-2];
            end else if (abort_s) begin
                miso_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_rx
//   Self-checking bench for spi_slave_rx. A behavioural mode-0 master drives
//   frames (SCLK = clk/8); a reference model of the TX buffer and received
//   words predicts rx_data, rx_valid/abort pulse counts, rx_valid latency and
//   the MISO bit stream seen by the master on each SCLK rise.
// ---------------------------------------------------------------------------
module tb_spi_slave_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         SCLK;
    logic         SS;
    logic         MOSI;
    logic         MISO;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         busy;
    logic         abort;

    spi_slave_rx #(.width(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .SCLK     (SCLK),
        .SS       (SS),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .abort    (abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse monitor, sampled on the falling edge.
    int valid_cnt = 0;
    int abort_cnt = 0;
    int valid_cyc = 0;
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
        end
        if (abort === 1'b1) abort_cnt = abort_cnt + 1;
    end

    // Reference model state.
    logic [W-1:0] m_buf;
    bit           m_full;
    logic [W-1:0] m_rx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic load_tx(input logic [W-1:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        if (!m_full) begin
            m_buf  = d;
            m_full = 1'b1;
        end
        check_eq("tx_ready_after_load", {31'd0, tx_ready}, 32'd0);
    endtask

    // One SS window with n SCLK pulses; bits[15] is sent first.
    // hs: offer hs_d in the cycle the slave detects the SS fall.
    // rst_at: pulse reset just before rise number rst_at (-1 = never).
    task automatic run_frame(input logic [15:0] bits, input int n, input bit hs,
                             input logic [W-1:0] hs_d, input int rst_at);
        logic [15:0]  got_miso;
        logic [15:0]  exp_miso;
        logic [W-1:0] word;
        bit           hs_ok;
        bit           was_reset;
        int           v0, a0, rise_c;
        v0 = valid_cnt;
        a0 = abort_cnt;
        got_miso  = 16'd0;
        exp_miso  = 16'd0;
        rise_c    = 0;
        was_reset = 1'b0;
        // Frame start: the buffer (or zeros) becomes the reply; a same-cycle
        // handshake only lands if the buffer was empty before the start.
        word   = m_full ? m_buf : {W{1'b0}};
        hs_ok  = hs && !m_full;
        m_full = 1'b0;
        if (hs_ok) begin
            m_buf  = hs_d;
            m_full = 1'b1;
        end

        @(negedge clk);
        SS   = 1'b0;
        MOSI = bits[15];
        tick(2);
        if (hs) begin
            tx_valid = 1'b1;
            tx_data  = hs_d;
        end
        tick(1);
        tx_valid = 1'b0;
        tick(1);
        check_eq("busy_in_frame", {31'd0, busy}, 32'd1);
        check_eq("tx_ready_at_start", {31'd0, tx_ready}, {31'd0, !m_full});

        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
                tick(2);
                was_reset = 1'b1;
                break;
            end
            got_miso[15-i] = MISO;
            SCLK = 1'b1;
            if (i == W - 1) rise_c = cyc;
            tick(4);
            SCLK = 1'b0;
            MOSI = (i < 15) ? bits[14-i] : 1'b0;
            tick(4);
        end
        SS = 1'b1;
        tick(8);

        if (was_reset) begin
            m_full = 1'b0;
            m_rx   = {W{1'b0}};
            check_eq("rst_no_valid", valid_cnt - v0, 32'd0);
            check_eq("rst_no_abort", abort_cnt - a0, 32'd0);
            check_eq("rst_rx_data", {24'd0, rx_data}, {24'd0, m_rx});
            check_eq("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        end else begin
            for (int i = 0; i < n && i < W; i++) exp_miso[15-i] = word[W-1-i];
            check_eq("miso_stream", {16'd0, got_miso}, {16'd0, exp_miso});
            if (n >= W) begin
                m_rx = bits[15:16-W];
                check_eq("valid_count", valid_cnt - v0, 32'd1);
                check_eq("abort_count", abort_cnt - a0, 32'd0);
                check_eq("valid_latency", valid_cyc - rise_c, 32'd3);
            end else begin
                check_eq("short_no_valid", valid_cnt - v0, 32'd0);
                check_eq("short_abort", abort_cnt - a0, 32'd1);
            end
            check_eq("rx_data", {24'd0, rx_data}, {24'd0, m_rx});
            check_eq("tx_ready_end", {31'd0, tx_ready}, {31'd0, !m_full});
        end
        check_eq("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] r;
        int          n;
        int          ra;
        rst      = 1'b1;
        SS       = 1'b1;
        SCLK     = 1'b0;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = {W{1'b0}};
        m_buf    = {W{1'b0}};
        m_full   = 1'b0;
        m_rx     = {W{1'b0}};
        tick(3);
        check_eq("reset_miso", {31'd0, MISO}, 32'd0);
        check_eq("reset_tx_ready", {31'd0, tx_ready}, 32'd1);
        check_eq("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check_eq("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_abort", {31'd0, abort}, 32'd0);
        rst = 1'b0;
        tick(6);
        check_eq("post_reset_abort", abort_cnt, 32'd0);

        // Reply 0xA5 while receiving 0x3C.
        load_tx(8'hA5);
        run_frame({8'h3C, 8'h00}, 8, 1'b0, 8'h00, -1);
        // Back-to-back 0xFF / 0x00 with an empty buffer.
        run_frame({8'hFF, 8'hFF}, 8, 1'b0, 8'h00, -1);
        run_frame({8'h00, 8'h00}, 8, 1'b0, 8'h00, -1);
        // SS released after 5 rises.
        r = 16'($urandom);
        run_frame(r, 5, 1'b0, 8'h00, -1);
        // Handshake coincident with frame start goes to the next frame.
        r = 16'($urandom);
        run_frame(r, 8, 1'b1, 8'h81, -1);
        r = 16'($urandom);
        run_frame(r, 8, 1'b0, 8'h00, -1);
        // Reset mid-frame at bit 4, then a full 0x5A frame.
        load_tx(8'h3E);
        r = 16'($urandom);
        run_frame(r, 8, 1'b0, 8'h00, 4);
        run_frame({8'h5A, 8'h00}, 8, 1'b0, 8'h00, -1);
        // Ten pulses in one window; pulses 9-10 ignored.
        r = 16'($urandom);
        run_frame({8'hC3, r[7:0]}, 10, 1'b0, 8'h00, -1);

        // Randomized frames.
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 1) == 1 && !m_full) load_tx(8'($urandom));
            r  = 16'($urandom);
            n  = int'($urandom_range(3, 11));
            ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
            run_frame(r, n, ($urandom_range(0, 3) == 0), 8'($urandom), ra);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
